// File: rtl/uart_cfg.sv
// Configurable UART: programmable baud divisor, optional parity, 1/2 stop bits,
// FWFT RX/TX FIFOs and sticky line-error flags.

module uart_cfg_fifo #(
   parameter int AW = 2,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_wr,
   input  logic          i_rd,
   input  logic [DW-1:0] i_wdata,
   output logic [DW-1:0] o_rdata,
   output logic          o_empty,
   output logic          o_full
);
   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0]   r_cnt;
   logic          w_push, w_pop;

   assign o_empty = (r_cnt == '0);
   assign o_full  = r_cnt[AW];
   // a pop in the same cycle frees the slot, so a full FIFO still accepts the write
   assign w_push  = i_wr && (!o_full || i_rd);
   assign w_pop   = i_rd && !o_empty;
   assign o_rdata = r_mem[r_rp];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= i_wdata;
   end
endmodule

module uart_cfg #(
   parameter int DBIT   = 8,
   parameter int FIFO_W = 2,
   parameter int DIV_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DIV_W-1:0] divisor,
   input  logic             parity_en,
   input  logic             parity_odd,
   input  logic             stop2,
   input  logic             rd_uart,
   input  logic             wr_uart,
   input  logic [DBIT-1:0]  w_data,
   input  logic             rx,
   output logic [DBIT-1:0]  r_data,
   output logic             rx_empty,
   output logic             rx_full,
   output logic             tx_full,
   output logic             tx_empty,
   output logic             tx,
   output logic             frame_err,
   output logic             parity_err,
   output logic             overrun,
   input  logic             clr_err
);
   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} st_t;

   // baud generator: divisor is captured on reload so a mid-period change never shortens a tick
   logic [DIV_W-1:0] r_cnt, r_div;
   logic             w_tick;

   assign w_tick = (r_cnt == r_div);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
         r_div <= '0;
      end else if (w_tick) begin
         r_cnt <= '0;
         r_div <= divisor;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   logic r_rx_s1, r_rx_s2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_s1 <= 1'b1;
         r_rx_s2 <= 1'b1;
      end else begin
         r_rx_s1 <= rx;
         r_rx_s2 <= r_rx_s1;
      end
   end

   st_t             r_rx_st;
   logic [3:0]      r_rx_s;
   logic [NW-1:0]   r_rx_n;
   logic [DBIT-1:0] r_rx_sh;
   logic            r_rx_pbit, r_rx_pen, r_rx_podd;
   logic            w_rx_eval, w_pbad, w_ferr, w_perr, w_rx_good, w_rx_push, w_ovr;
   logic            w_rxf_full;

   // stop-bit sample: the single point where a frame is judged
   assign w_rx_eval = (r_rx_st == ST_STOP) && w_tick && (r_rx_s == 4'd15);
   assign w_pbad    = r_rx_pen && (r_rx_pbit != ((^r_rx_sh) ^ r_rx_podd));
   assign w_ferr    = w_rx_eval && !r_rx_s2;
   assign w_perr    = w_rx_eval && w_pbad;
   assign w_rx_good = w_rx_eval && r_rx_s2 && !w_pbad;
   assign w_rx_push = w_rx_good && !w_rxf_full;
   assign w_ovr     = w_rx_good && w_rxf_full;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_st   <= ST_IDLE;
         r_rx_s    <= '0;
         r_rx_n    <= '0;
         r_rx_sh   <= '0;
         r_rx_pbit <= 1'b0;
         r_rx_pen  <= 1'b0;
         r_rx_podd <= 1'b0;
      end else begin
         case (r_rx_st)
            ST_IDLE: if (!r_rx_s2) begin
               r_rx_st   <= ST_START;
               r_rx_s    <= '0;
               r_rx_pen  <= parity_en;
               r_rx_podd <= parity_odd;
            end
            ST_START: if (w_tick) begin
               if (r_rx_s == 4'd7) begin
                  r_rx_st <= r_rx_s2 ? ST_IDLE : ST_DATA;
                  r_rx_s  <= '0;
                  r_rx_n  <= '0;
               end else begin
                  r_rx_s <= r_rx_s + 4'd1;
               end
            end
            ST_DATA: if (w_tick) begin
               if (r_rx_s == 4'd15) begin
                  r_rx_s  <= '0;
                  r_rx_sh <= {r_rx_s2, r_rx_sh[DBIT-1:1]};
                  if (r_rx_n == NW'(DBIT-1)) r_rx_st <= r_rx_pen ? ST_PAR : ST_STOP;
                  else                       r_rx_n  <= r_rx_n + 1'b1;
               end else begin
                  r_rx_s <= r_rx_s + 4'd1;
               end
            end
            ST_PAR: if (w_tick) begin
               if (r_rx_s == 4'd15) begin
                  r_rx_s    <= '0;
                  r_rx_pbit <= r_rx_s2;
                  r_rx_st   <= ST_STOP;
               end else begin
                  r_rx_s <= r_rx_s + 4'd1;
               end
            end
            ST_STOP: if (w_tick) begin
               if (r_rx_s == 4'd15) r_rx_st <= ST_IDLE;
               else                 r_rx_s  <= r_rx_s + 4'd1;
            end
            default: r_rx_st <= ST_IDLE;
         endcase
      end
   end

   logic r_ferr, r_perr, r_ovr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ferr <= 1'b0;
         r_perr <= 1'b0;
         r_ovr  <= 1'b0;
      end else begin
         if (w_ferr)       r_ferr <= 1'b1;
         else if (clr_err) r_ferr <= 1'b0;
         if (w_perr)       r_perr <= 1'b1;
         else if (clr_err) r_perr <= 1'b0;
         if (w_ovr)        r_ovr  <= 1'b1;
         else if (clr_err) r_ovr  <= 1'b0;
      end
   end

   uart_cfg_fifo #(.AW(FIFO_W), .DW(DBIT)) u_rxf (
      .clk     (clk),
      .reset   (reset),
      .i_wr    (w_rx_push),
      .i_rd    (rd_uart),
      .i_wdata (r_rx_sh),
      .o_rdata (r_data),
      .o_empty (rx_empty),
      .o_full  (w_rxf_full)
   );

   st_t             r_tx_st;
   logic [4:0]      r_tx_s;
   logic [NW-1:0]   r_tx_n;
   logic [DBIT-1:0] r_tx_sh;
   logic            r_tx_pbit, r_tx_pen, r_tx_stop2, r_tx;
   logic [DBIT-1:0] w_txf_dout;
   logic            w_txf_empty, w_tx_pop;

   assign w_tx_pop = (r_tx_st == ST_IDLE) && w_tick && !w_txf_empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tx_st    <= ST_IDLE;
         r_tx_s     <= '0;
         r_tx_n     <= '0;
         r_tx_sh    <= '0;
         r_tx_pbit  <= 1'b0;
         r_tx_pen   <= 1'b0;
         r_tx_stop2 <= 1'b0;
         r_tx       <= 1'b1;
      end else begin
         case (r_tx_st)
            ST_IDLE: if (w_tx_pop) begin
               r_tx_st    <= ST_START;
               r_tx_s     <= '0;
               r_tx_sh    <= w_txf_dout;
               r_tx_pbit  <= (^w_txf_dout) ^ parity_odd;
               r_tx_pen   <= parity_en;
               r_tx_stop2 <= stop2;
               r_tx       <= 1'b0;
            end
            ST_START: if (w_tick) begin
               if (r_tx_s == 5'd15) begin
                  r_tx_st <= ST_DATA;
                  r_tx_s  <= '0;
                  r_tx_n  <= '0;
                  r_tx    <= r_tx_sh[0];
               end else begin
                  r_tx_s <= r_tx_s + 5'd1;
               end
            end
            ST_DATA: if (w_tick) begin
               if (r_tx_s == 5'd15) begin
                  r_tx_s <= '0;
                  if (r_tx_n == NW'(DBIT-1)) begin
                     r_tx_st <= r_tx_pen ? ST_PAR : ST_STOP;
                     r_tx    <= r_tx_pen ? r_tx_pbit : 1'b1;
                  end else begin
                     r_tx_n  <= r_tx_n + 1'b1;
                     r_tx_sh <= r_tx_sh >> 1;
                     r_tx    <= r_tx_sh[1];
                  end
               end else begin
                  r_tx_s <= r_tx_s + 5'd1;
               end
            end
            ST_PAR: if (w_tick) begin
               if (r_tx_s == 5'd15) begin
                  r_tx_st <= ST_STOP;
                  r_tx_s  <= '0;
                  r_tx    <= 1'b1;
               end else begin
                  r_tx_s <= r_tx_s + 5'd1;
               end
            end
            ST_STOP: if (w_tick) begin
               if (r_tx_s == (r_tx_stop2 ? 5'd31 : 5'd15)) r_tx_st <= ST_IDLE;
               else                                        r_tx_s  <= r_tx_s + 5'd1;
            end
            default: r_tx_st <= ST_IDLE;
         endcase
      end
   end

   uart_cfg_fifo #(.AW(FIFO_W), .DW(DBIT)) u_txf (
      .clk     (clk),
      .reset   (reset),
      .i_wr    (wr_uart),
      .i_rd    (w_tx_pop),
      .i_wdata (w_data),
      .o_rdata (w_txf_dout),
      .o_empty (w_txf_empty),
      .o_full  (tx_full)
   );

   assign tx         = r_tx;
   assign tx_empty   = w_txf_empty && (r_tx_st == ST_IDLE);
   assign rx_full    = w_rxf_full;
   assign frame_err  = r_ferr;
   assign parity_err = r_perr;
   assign overrun    = r_ovr;
endmodule
